// File: rtl/ppg_frontend_model.sv
// Synthesizable stand-in for the PPG analog front end: heartbeat shape, settle/convert control, 2-stage ADC pipeline.
// Define FE_NOISE_EN to add LFSR dither (-4..+3 LSB) to each conversion.
module ppg_frontend_model #(
    parameter int DC_RED     = 160,
    parameter int DC_IR      = 180,
    parameter int AC_RED     = 20,
    parameter int AC_IR      = 30,
    parameter int COMP_STEP  = 8,
    parameter int HR_PERIOD  = 1000,
    parameter int FALL_DIV   = 8,
    parameter int SETTLE_CYC = 4,
    parameter int SAMPLE_DIV = 1
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       LED_RED,
    input  logic       LED_IR,
    input  logic [3:0] LED_DRIVE,
    input  logic [6:0] DC_Comp,
    input  logic [3:0] PGA_Gain,
    output logic [7:0] ADC,
    output logic       ADC_valid,
    output logic       LED_fault
);
    localparam int BW = (HR_PERIOD > 1) ? $clog2(HR_PERIOD) : 1;
    localparam int FW = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [BW-1:0] BEAT_LAST   = BW'(HR_PERIOD - 1);
    localparam logic [FW-1:0] FALL_LAST   = FW'(FALL_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [7:0]    DIV_LAST    = 8'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {RISE, FALL, REST} shape_st_t;
    typedef enum logic {SETTLE, CONVERT} front_st_t;
    typedef struct packed {
        logic       red;
        logic       ir;
        logic [3:0] drive;
        logic [6:0] comp;
        logic [3:0] gain;
    } cfg_t;

    shape_st_t       shape_st, shape_st_nx;
    logic [5:0]      shape, shape_nx;
    logic [FW-1:0]   fcnt, fcnt_nx;
    logic [BW-1:0]   beat_cnt, beat_nx;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            shape_st <= RISE;
            shape    <= '0;
            fcnt     <= '0;
            beat_cnt <= '0;
        end else begin
            shape_st <= shape_st_nx;
            shape    <= shape_nx;
            fcnt     <= fcnt_nx;
            beat_cnt <= beat_nx;
        end
    end

    // Beat wrap restarts the rise from wherever the shape currently is.
    always_comb begin
        shape_st_nx = shape_st;
        shape_nx    = shape;
        fcnt_nx     = fcnt;
        beat_nx     = beat_cnt + BW'(1);
        if (beat_cnt == BEAT_LAST) begin
            beat_nx     = '0;
            shape_st_nx = RISE;
            fcnt_nx     = '0;
        end else begin
            case (shape_st)
                RISE: begin
                    if (shape == 6'd63) begin
                        shape_st_nx = FALL;
                        fcnt_nx     = '0;
                    end else begin
                        shape_nx = shape + 6'd1;
                    end
                end
                FALL: begin
                    if (shape == 6'd0) begin
                        shape_st_nx = REST;
                    end else if (fcnt == FALL_LAST) begin
                        fcnt_nx  = '0;
                        shape_nx = shape - 6'd1;
                    end else begin
                        fcnt_nx = fcnt + FW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    cfg_t            cfg, cfg_q;
    logic            changed, strobe;
    front_st_t       front, front_nx;
    logic [SW-1:0]   settle_cnt, settle_nx;
    logic [7:0]      div_cnt, div_nx;

    assign cfg     = {LED_RED, LED_IR, LED_DRIVE, DC_Comp, PGA_Gain};
    assign changed = (cfg != cfg_q);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            front      <= SETTLE;
            settle_cnt <= '0;
            div_cnt    <= '0;
            cfg_q      <= '0;
        end else begin
            front      <= front_nx;
            settle_cnt <= settle_nx;
            div_cnt    <= div_nx;
            cfg_q      <= cfg;
        end
    end

    always_comb begin
        front_nx  = front;
        settle_nx = settle_cnt;
        div_nx    = div_cnt;
        strobe    = 1'b0;
        if (changed) begin
            front_nx  = SETTLE;
            settle_nx = '0;
        end else if (front == SETTLE) begin
            if (settle_cnt == SETTLE_LAST) begin
                front_nx = CONVERT;
                div_nx   = '0;
            end else begin
                settle_nx = settle_cnt + SW'(1);
            end
        end else if (div_cnt == DIV_LAST) begin
            strobe = 1'b1;
            div_nx = '0;
        end else begin
            div_nx = div_cnt + 8'd1;
        end
    end

    cfg_t              s1_cfg;
    logic [5:0]        s1_shape;
    logic [2:1]        vld_pipe;
    logic              lit_red, lit_ir;
    logic [7:0]        dc;
    logic [5:0]        ac_amp;
    logic [11:0]       ac_prod, comp_sub;
    logic [8:0]        dcac;
    logic [12:0]       photo_full;
    logic [9:0]        photo;
    logic [4:0]        gain_p1;
    logic signed [11:0] diff;
    logic signed [16:0] amp;
    logic signed [17:0] sum;
    logic [7:0]        adc_nx;

`ifdef FE_NOISE_EN
    logic [15:0]       lfsr;
    logic [2:0]        s1_noise;
    logic signed [3:0] noise;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= 16'hACE1;
            s1_noise <= '0;
        end else if (strobe) begin
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            s1_noise <= lfsr[2:0];
        end
    end
    assign noise = $signed({1'b0, s1_noise}) - 4'sd4;
`endif

    // Stage 2: photodiode, DC compensation, PGA and clamp; both-lit counts as dark.
    always_comb begin
        lit_red    = s1_cfg.red & ~s1_cfg.ir;
        lit_ir     = s1_cfg.ir & ~s1_cfg.red;
        dc         = lit_ir ? 8'(DC_IR) : 8'(DC_RED);
        ac_amp     = lit_ir ? 6'(AC_IR) : 6'(AC_RED);
        ac_prod    = 12'(s1_shape) * 12'(ac_amp);
        dcac       = 9'(dc) + 9'(ac_prod >> 6);
        photo_full = 13'(dcac) * 13'(s1_cfg.drive);
        photo      = (lit_red | lit_ir) ? 10'(photo_full >> 3) : 10'd0;
        comp_sub   = 12'(s1_cfg.comp) * 12'(COMP_STEP);
        diff       = $signed({2'b00, photo}) - $signed(comp_sub);
        gain_p1    = {1'b0, s1_cfg.gain} + 5'd1;
        amp        = 17'(diff) * $signed({12'b0, gain_p1});
`ifdef FE_NOISE_EN
        sum        = 18'(amp) + 18'(noise) + 18'sd128;
`else
        sum        = 18'(amp) + 18'sd128;
`endif
        if (sum < 18'sd0)        adc_nx = 8'd0;
        else if (sum > 18'sd255) adc_nx = 8'd255;
        else                     adc_nx = sum[7:0];
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s1_cfg    <= '0;
            s1_shape  <= '0;
            vld_pipe  <= '0;
            ADC       <= 8'd128;
            LED_fault <= 1'b0;
        end else begin
            vld_pipe[1] <= strobe;
            vld_pipe[2] <= vld_pipe[1] & ~changed;
            if (strobe) begin
                s1_cfg   <= cfg;
                s1_shape <= shape;
            end
            if (vld_pipe[1] & ~changed) ADC <= adc_nx;
            LED_fault <= LED_RED & LED_IR;
        end
    end

    assign ADC_valid = vld_pipe[2];
endmodule

// File: tb/tb_ppg_frontend_model.sv
// Randomized bench for ppg_frontend_model: two instances (SAMPLE_DIV 1 and 5) against a cycle-schedule reference model.
module tb_ppg_frontend_model;
    localparam int HR = 1000, SETTLE = 4, MAXC = 7000;

    logic       CLK = 1'b0, rst_n = 1'b0;
    logic       r = 1'b0, i = 1'b0;
    logic [3:0] drv = '0, gn = '0;
    logic [6:0] cmp = '0;
    logic [7:0] adc1, adc5;
    logic       vld1, vld5, flt1, flt5;

    ppg_frontend_model #(.SAMPLE_DIV(1)) dut1 (
        .CLK(CLK), .rst_n(rst_n), .LED_RED(r), .LED_IR(i), .LED_DRIVE(drv),
        .DC_Comp(cmp), .PGA_Gain(gn), .ADC(adc1), .ADC_valid(vld1), .LED_fault(flt1));
    ppg_frontend_model #(.SAMPLE_DIV(5)) dut5 (
        .CLK(CLK), .rst_n(rst_n), .LED_RED(r), .LED_IR(i), .LED_DRIVE(drv),
        .DC_Comp(cmp), .PGA_Gain(gn), .ADC(adc5), .ADC_valid(vld5), .LED_fault(flt5));

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int n, last_chg, e_adc1, e_adc5;
    logic [16:0] prev;
    logic [16:0] hist [MAXC];
    bit          chg  [MAXC];
    bit          stb1 [MAXC];
    bit          stb5 [MAXC];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s cyc=%0d got %0d exp %0d", tag, n, obs, exp);
        end
    endtask

    // Heartbeat shape as a function of cycles since reset release.
    function automatic int shape_at(input int c);
        int p, s;
        p = c % HR;
        if (p <= 63) return p;
        s = 63 - (p - 64) / 8;
        return (s < 0) ? 0 : s;
    endfunction

    function automatic int adc_ref(input logic [16:0] c, input int sh);
        int rr, ii, dd, cc, gg, photo, v;
        rr = int'(c[16]); ii = int'(c[15]); dd = int'(c[14:11]);
        cc = int'(c[10:4]); gg = int'(c[3:0]);
        photo = 0;
        if (rr != ii) photo = (((rr != 0) ? 160 : 180) + (sh * ((rr != 0) ? 20 : 30)) / 64) * dd / 8;
        v = 128 + (photo - cc * 8) * (gg + 1);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic bit strobe_ref(input int c, input int d);
        int cs;
        cs = last_chg + SETTLE + 1;
        return !chg[c] && (c >= cs) && (((c - cs) % d) == d - 1);
    endfunction

    task automatic model_reset();
        n = 0; last_chg = -1; prev = '0; e_adc1 = 128; e_adc5 = 128;
    endtask

    // Check outputs for cycle n, then record the inputs this cycle applies.
    task automatic step();
        bit v1, v5, f;
        v1 = (n >= 2) && stb1[n-2] && !chg[n-1];
        v5 = (n >= 2) && stb5[n-2] && !chg[n-1];
        if (v1) e_adc1 = adc_ref(hist[n-2], shape_at(n-2));
        if (v5) e_adc5 = adc_ref(hist[n-2], shape_at(n-2));
        f = (n >= 1) && hist[n-1][16] && hist[n-1][15];
        chk("adc1", int'(adc1), e_adc1);
        chk("vld1", int'(vld1), int'(v1));
        chk("flt1", int'(flt1), int'(f));
        chk("adc5", int'(adc5), e_adc5);
        chk("vld5", int'(vld5), int'(v5));
        chk("flt5", int'(flt5), int'(f));
        hist[n] = {r, i, drv, cmp, gn};
        chg[n]  = (hist[n] != prev);
        prev    = hist[n];
        if (chg[n]) last_chg = n;
        stb1[n] = strobe_ref(n, 1);
        stb5[n] = strobe_ref(n, 5);
        n++;
    endtask

    task automatic base_cfg();
        r = 1'b1; i = 1'b0; drv = 4'd10; cmp = 7'd25; gn = 4'd0;
    endtask

    task automatic mutate();
        case ($urandom_range(5))
            0: r   = ~r;
            1: i   = ~i;
            2: drv = 4'($urandom_range(15));
            3: cmp = 7'($urandom_range(127));
            4: gn  = 4'($urandom_range(15));
            default: begin cmp = ($urandom_range(1) != 0) ? 7'd127 : 7'd0; gn = 4'd15; end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", n);
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        base_cfg();
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        step();
        while (n < 6500) begin
            @(negedge CLK);
            case (n)
                1000: gn = 4'd3;
                2000: gn = 4'd7;
                3000: begin cmp = 7'd127; gn = 4'd15; end
                4000: begin i = 1'b1; cmp = 7'd0; gn = 4'd0; end
                4500: begin i = 1'b0; cmp = 7'd25; end
                default: ;
            endcase
            if (n >= 4600 && n < 4610 && (n % 2) == 0) cmp = cmp ^ 7'd1;
            if (n >= 5000 && $urandom_range(7) == 0) mutate();
            step();
        end
        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("rst_adc1", int'(adc1), 128);
        chk("rst_vld1", int'(vld1), 0);
        chk("rst_flt1", int'(flt1), 0);
        chk("rst_adc5", int'(adc5), 128);
        chk("rst_vld5", int'(vld5), 0);
        chk("rst_flt5", int'(flt5), 0);
        repeat (2) @(negedge CLK);
        model_reset();
        base_cfg();
        rst_n = 1'b1;
        step();
        while (n < 200) begin
            @(negedge CLK);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
